// File: rtl/dvp_frame_tx.sv
// Replays RGB565 pixels from a frame buffer as an 8-bit DVP stream (pclk = clk/2, high byte first).
// Every state, sync and data change lands on a dvp_pclk fall edge; reads are prefetched one pixel ahead.
module dvp_frame_tx #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned VSYNC_LEN  = 4,
    parameter int unsigned VBP_LEN    = 8,
    parameter int unsigned HBLANK_LEN = 16,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              rden,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic [15:0]       rddata,
    output logic              dvp_pclk,
    output logic              dvp_vsync,
    output logic              dvp_hsync,
    output logic [7:0]        dvp_data
);
    localparam int unsigned LINE_LEN = 2 * H_ACTIVE;
    localparam int unsigned MAX_A    = (VSYNC_LEN > VBP_LEN) ? VSYNC_LEN : VBP_LEN;
    localparam int unsigned MAX_B    = (LINE_LEN > HBLANK_LEN) ? LINE_LEN : HBLANK_LEN;
    localparam int unsigned MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);
    localparam int unsigned LINE_W   = $clog2(V_ACTIVE + 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBLANK} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [LINE_W-1:0]   line, line_n;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [15:0]         pix, nxt;
    logic                pending, rd_pend;
    logic                fall, go, done_n, fetch, load_pix;

    assign fall = dvp_pclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            line       <= '0;
            fetch_addr <= '0;
            pix        <= '0;
            nxt        <= '0;
            pending    <= 1'b0;
            rd_pend    <= 1'b0;
            rden       <= 1'b0;
            rdaddr     <= '0;
            frame_done <= 1'b0;
            dvp_pclk   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            line       <= line_n;
            dvp_pclk   <= ~dvp_pclk;
            frame_done <= done_n;
            rd_pend    <= rden;
            rden       <= 1'b0;
            if (state == IDLE) begin
                if (go)
                    pending <= 1'b0;
                else if (start && !frame_done)
                    pending <= 1'b1;
            end
            if (go)
                fetch_addr <= '0;
            if (fetch) begin
                rden       <= 1'b1;
                rdaddr     <= fetch_addr;
                fetch_addr <= fetch_addr + ADDR_W'(1);
            end
            if (rd_pend)
                nxt <= rddata;
            // Line-start fetch returns on the very edge that presents it, so bypass nxt.
            if (load_pix)
                pix <= rd_pend ? rddata : nxt;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        line_n  = line;
        done_n  = 1'b0;
        go      = 1'b0;
        if (fall) begin
            unique case (state)
                IDLE: begin
                    go = pending || (start && !frame_done);
                    if (go) begin
                        state_n = VSYNC;
                        cnt_n   = '0;
                        line_n  = '0;
                    end
                end
                VSYNC: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(VSYNC_LEN - 1)) begin
                        state_n = VBP;
                        cnt_n   = '0;
                    end
                end
                VBP: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(VBP_LEN - 1)) begin
                        state_n = LINE;
                        cnt_n   = '0;
                    end
                end
                LINE: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LINE_LEN - 1)) begin
                        state_n = HBLANK;
                        cnt_n   = '0;
                    end
                end
                HBLANK: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(HBLANK_LEN - 1)) begin
                        cnt_n = '0;
                        if (line == LINE_W'(V_ACTIVE - 1)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = LINE;
                            line_n  = line + LINE_W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        load_pix = fall && (state_n == LINE) && !cnt_n[0];
        fetch = fall && (
                   ((state_n == VBP) && (cnt_n == CNT_W'(VBP_LEN - 1))) ||
                   ((state_n == HBLANK) && (cnt_n == CNT_W'(HBLANK_LEN - 1)) &&
                    (line != LINE_W'(V_ACTIVE - 1))) ||
                   (load_pix && ((cnt_n >> 1) < CNT_W'(H_ACTIVE - 1))));
    end

    always_comb begin
        busy      = (state != IDLE);
        dvp_vsync = (state == VSYNC);
        dvp_hsync = (state == LINE);
        dvp_data  = '0;
        if (state == LINE)
            dvp_data = cnt[0] ? pix[7:0] : pix[15:8];
    end
endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench for dvp_frame_tx with a 4x2 frame and a 1-clk-latency buffer holding 16'h1000+addr.
module tb_dvp_frame_tx;
    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, frame_done, rden;
    logic [19:0] rdaddr;
    logic [15:0] rddata;
    logic        dvp_pclk, dvp_vsync, dvp_hsync;
    logic [7:0]  dvp_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] byte_q[$];
    int         addr_q[$];
    int         rd_cyc_q[$];
    int         hs_rise_q[$];
    int         hs_fall_q[$];
    int         done_q[$];
    int         vs_rise, vs_fall, rd_in_vs;
    logic       vs_prev = 1'b0, hs_prev = 1'b0;

    dvp_frame_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .VSYNC_LEN(3), .VBP_LEN(2), .HBLANK_LEN(2), .ADDR_W(20)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata), .dvp_pclk(dvp_pclk),
        .dvp_vsync(dvp_vsync), .dvp_hsync(dvp_hsync), .dvp_data(dvp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rden) rddata <= 16'h1000 + rdaddr[15:0];
    end

    always @(negedge clk) begin
        if (dvp_pclk && dvp_hsync) byte_q.push_back(dvp_data);
        if (rden) begin
            addr_q.push_back(int'(rdaddr));
            rd_cyc_q.push_back(cyc);
            if (dvp_vsync) rd_in_vs++;
        end
        if (dvp_vsync && !vs_prev) vs_rise = cyc;
        if (!dvp_vsync && vs_prev) vs_fall = cyc;
        if (dvp_hsync && !hs_prev) hs_rise_q.push_back(cyc);
        if (!dvp_hsync && hs_prev) hs_fall_q.push_back(cyc);
        if (frame_done) done_q.push_back(cyc);
        vs_prev = dvp_vsync;
        hs_prev = dvp_hsync;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        byte_q.delete(); addr_q.delete(); rd_cyc_q.delete();
        hs_rise_q.delete(); hs_fall_q.delete(); done_q.delete();
        rd_in_vs = 0; vs_rise = -1; vs_fall = -1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 2000 && !frame_done; i++) tick();
        check_eq(tag, frame_done, 1'b1);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] exp_b;
        check_eq({tag, "_nbytes"}, byte_q.size(), 16);
        for (int k = 0; k < 16 && k < byte_q.size(); k++) begin
            exp_b = (k % 2 == 0) ? 8'h10 : 8'(k / 2);
            check_eq({tag, "_byte"}, byte_q[k], exp_b);
        end
        check_eq({tag, "_nreads"}, addr_q.size(), 8);
        for (int k = 0; k < 8 && k < addr_q.size(); k++)
            check_eq({tag, "_rdaddr"}, addr_q[k], k);
    endtask

    initial begin
        int err, tgl_err, late_rd;
        logic prev_pclk;
        reset = 1'b1;
        start = 1'b0;
        clear_log();
        repeat (3) tick();
        reset = 1'b0;

        // quiet idle after reset
        err = 0; tgl_err = 0;
        prev_pclk = dvp_pclk;
        check_eq("reset_pclk", dvp_pclk, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy || dvp_vsync || dvp_hsync || dvp_data != 8'h00 || rden || frame_done) err++;
            if (dvp_pclk == prev_pclk) tgl_err++;
            prev_pclk = dvp_pclk;
        end
        check_eq("idle_quiet", err, 0);
        check_eq("pclk_toggle", tgl_err, 0);

        // single frame: data, timing and read sequence
        clear_log();
        pulse_start();
        wait_done("frame1_done");
        repeat (20) tick();
        check_frame("f1");
        check_eq("vsync_len", vs_fall - vs_rise, 6);
        check_eq("rd_in_vsync", rd_in_vs, 0);
        check_eq("done_count", done_q.size(), 1);
        check_eq("hs_rises", hs_rise_q.size(), 2);
        check_eq("hs_falls", hs_fall_q.size(), 2);
        if (hs_rise_q.size() == 2 && hs_fall_q.size() == 2 && done_q.size() >= 1) begin
            check_eq("vbp_gap", hs_rise_q[0] - vs_fall, 4);
            check_eq("line0_len", hs_fall_q[0] - hs_rise_q[0], 16);
            check_eq("hblank_gap", hs_rise_q[1] - hs_fall_q[0], 4);
            check_eq("line1_len", hs_fall_q[1] - hs_rise_q[1], 16);
            check_eq("last_hblank", done_q[0] - hs_fall_q[1], 4);
            check_eq("frame_len", done_q[0] - vs_rise, 50);
            late_rd = 0;
            foreach (rd_cyc_q[k]) if (rd_cyc_q[k] > hs_fall_q[1]) late_rd++;
            check_eq("rd_final_hblank", late_rd, 0);
        end
        check_eq("idle_busy", busy, 1'b0);

        // stray starts while busy and coincident with frame_done
        clear_log();
        pulse_start();
        repeat (10) tick();
        check_eq("busy_mid", busy, 1'b1);
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_done("frame2_done");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (200) tick();
        check_eq("ign_done_count", done_q.size(), 1);
        check_eq("ign_reads", addr_q.size(), 8);
        check_eq("ign_busy", busy, 1'b0);

        // reset during line 1 byte 3
        clear_log();
        pulse_start();
        for (int i = 0; i < 2000 && byte_q.size() < 11; i++) tick();
        check_eq("reach_l1b3", byte_q.size(), 11);
        check_eq("l1b3_data", dvp_data, 8'h05);
        reset = 1'b1;
        tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_vsync", dvp_vsync, 1'b0);
        check_eq("rst_hsync", dvp_hsync, 1'b0);
        check_eq("rst_data", dvp_data, 8'h00);
        check_eq("rst_rden", rden, 1'b0);
        check_eq("rst_rdaddr", rdaddr, 20'h0);
        check_eq("rst_pclk", dvp_pclk, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        reset = 1'b0;
        repeat (100) tick();
        check_eq("abort_no_done", done_q.size(), 0);
        clear_log();
        pulse_start();
        wait_done("frame3_done");
        repeat (20) tick();
        check_frame("f3");
        check_eq("f3_done_count", done_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
